// File: rtl/vga_display_ctrl_pkg.sv
// Shared types and constants for the VGA display controller: pixel source modes and the colour-bar table.
package vga_display_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_FB    = 2'd0,
      MODE_BARS  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_SOLID = 2'd3
   } mode_e;

   // {R,G,B} channel enables per bar; index 0 is the leftmost bar (W,Y,C,G,M,R,B,K)
   localparam logic [7:0][2:0] BAR_RGB = {3'b000, 3'b001, 3'b100, 3'b101,
                                          3'b010, 3'b011, 3'b110, 3'b111};

   function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
      return BAR_RGB[idx];
   endfunction

endpackage

// File: rtl/vga_display_ctrl_if.sv
// Frame-buffer read port: registered address/enable out, BRAM data back after the BRAM latency.
interface vga_display_ctrl_if #(
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 12
);
   logic [ADDR_W-1:0] pix_addr;
   logic              pix_rd;
   logic [PIX_W-1:0]  pix_data;

   modport master (output pix_addr, output pix_rd, input pix_data);
   modport slave  (input pix_addr, input pix_rd, output pix_data);
endinterface

// File: rtl/vga_display_ctrl_sync_gen.sv
// Raster timing: free-running h/v counters with raw sync levels, active-video flag and frame markers.
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int XW      = $clog2(H_TOTAL),
   localparam int YW      = $clog2(V_TOTAL)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic [XW-1:0] h_o,
   output logic [YW-1:0] v_o,
   output logic          hsync_o,
   output logic          vsync_o,
   output logic          video_o,
   output logic          sof_o,
   output logic          eol_o,
   output logic          eof_o,
   output logic          frame_start_o
);

   logic [XW-1:0] h_q, h_d;
   logic [YW-1:0] v_q, v_d;
   logic          fs_q;
   logic          eol, eof, hs_act, vs_act;

   assign eol = (32'(h_q) == H_TOTAL - 1);
   assign eof = eol && (32'(v_q) == V_TOTAL - 1);

   always_comb begin
      h_d = h_q + 1'b1;
      v_d = v_q;
      if (eol) begin
         h_d = '0;
         v_d = eof ? '0 : v_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         h_q  <= '0;
         v_q  <= '0;
         fs_q <= 1'b0;
      end else begin
         h_q  <= h_d;
         v_q  <= v_d;
         fs_q <= sof_o;
      end
   end

   assign hs_act = (32'(h_q) >= H_ACTIVE + H_FP) && (32'(h_q) < H_ACTIVE + H_FP + H_SYNC);
   assign vs_act = (32'(v_q) >= V_ACTIVE + V_FP) && (32'(v_q) < V_ACTIVE + V_FP + V_SYNC);

   assign h_o           = h_q;
   assign v_o           = v_q;
   assign hsync_o       = hs_act ? SYNC_POL : ~SYNC_POL;
   assign vsync_o       = vs_act ? SYNC_POL : ~SYNC_POL;
   assign video_o       = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
   assign sof_o         = (h_q == '0) && (v_q == '0);
   assign eol_o         = eol;
   assign eof_o         = eof;
   // registered so it is low in reset and first fires one clock after release
   assign frame_start_o = fs_q;

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA display controller: raster timing, frame-buffer addressing with 1x/2x replication,
// test patterns, and a delay line that keeps sync/video/coords aligned with BRAM read data.
module vga_display_ctrl
   import vga_display_ctrl_pkg::*;
#(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0,
   parameter int CH_W     = 4,
   parameter int FB_W     = 640,
   parameter int FB_H     = 480,
   parameter int ADDR_W   = 19,
   parameter int BRAM_LAT = 1,
   localparam int PIX_W   = 3 * CH_W,
   localparam int XW      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
   localparam int YW      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [1:0]        i_mode,
   input  logic              i_scale,
   vga_display_ctrl_if.master fb,
   output logic              o_hsync,
   output logic              o_vsync,
   output logic              o_video,
   output logic [XW-1:0]     o_x,
   output logic [YW-1:0]     o_y,
   output logic [CH_W-1:0]   o_red,
   output logic [CH_W-1:0]   o_green,
   output logic [CH_W-1:0]   o_blue,
   output logic              o_frame_start
);

   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam int STG   = BRAM_LAT + 1;

   typedef struct packed {
      logic          hsync;
      logic          vsync;
      logic          video;
      logic          rd;
      logic [2:0]    pat;
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } pix_t;

   localparam pix_t PIX_IDLE = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, default: '0};

   logic [XW-1:0] h;
   logic [YW-1:0] v;
   logic          hsync0, vsync0, video0, sof, eol, eof;

   vga_sync_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(SYNC_POL)
   ) u_sync (
      .clk_i        (i_clk),
      .rst_i        (i_rst),
      .h_o          (h),
      .v_o          (v),
      .hsync_o      (hsync0),
      .vsync_o      (vsync0),
      .video_o      (video0),
      .sof_o        (sof),
      .eol_o        (eol),
      .eof_o        (eof),
      .frame_start_o(o_frame_start)
   );

   // Mode/scale latched as the counter enters (0,0) and used by that pixel too,
   // so a whole frame is rendered with one setting.
   mode_e mode_q, mode_d;
   logic  scale_q, scale_d;

   always_comb begin
      mode_d  = mode_q;
      scale_d = scale_q;
      if (sof) begin
         mode_d  = mode_e'(i_mode);
         scale_d = i_scale;
      end
   end

   logic [XW-1:0]     fx;
   logic [YW-1:0]     fy;
   logic              in_fb, rd0;
   logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;

   assign fx    = h >> scale_d;
   assign fy    = v >> scale_d;
   assign in_fb = (32'(fx) < FB_W) && (32'(fy) < FB_H);
   assign rd0   = video0 && (mode_d == MODE_FB) && in_fb;
   assign addr_d = rd0 ? row_base_q + ADDR_W'(fx) : '0;

   // Row base tracks fy*FB_W incrementally; in 2x mode each FB row is shown on two lines.
   always_comb begin
      row_base_d = row_base_q;
      if (eof)
         row_base_d = '0;
      else if (eol && (32'(v) < V_ACTIVE) && (!scale_q || v[0]))
         row_base_d = row_base_q + ADDR_W'(FB_W);
   end

   logic [2:0]    bar_idx_q, bar_idx_d;
   logic [XW-1:0] bar_pos_q, bar_pos_d;

   always_comb begin
      bar_idx_d = bar_idx_q;
      bar_pos_d = bar_pos_q + 1'b1;
      if (eol) begin
         bar_idx_d = '0;
         bar_pos_d = '0;
      end else if (32'(bar_pos_q) == BAR_W - 1) begin
         bar_pos_d = '0;
         if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 1'b1;
      end
   end

   logic [2:0] pat0;

   always_comb begin
      case (mode_d)
         MODE_BARS:  pat0 = bar_rgb(bar_idx_q);
         MODE_CHECK: pat0 = {3{h[5] ^ v[5]}};
         MODE_SOLID: pat0 = 3'b001;
         default:    pat0 = 3'b000;
      endcase
   end

   pix_t              pix0, last;
   pix_t [STG-1:0]    pipe_q;
   logic              hsync_q, vsync_q, video_q;
   logic [XW-1:0]     x_q;
   logic [YW-1:0]     y_q;
   logic [PIX_W-1:0]  rgb_q, rgb_d;

   assign pix0 = '{hsync: hsync0, vsync: vsync0, video: video0, rd: rd0,
                   pat: pat0, x: h, y: v};
   assign last = pipe_q[STG-1];

   always_comb begin
      rgb_d = '0;
      if (last.video)
         rgb_d = last.rd ? fb.pix_data
                         : {{CH_W{last.pat[2]}}, {CH_W{last.pat[1]}}, {CH_W{last.pat[0]}}};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         mode_q     <= MODE_FB;
         scale_q    <= 1'b0;
         row_base_q <= '0;
         bar_idx_q  <= '0;
         bar_pos_q  <= '0;
         addr_q     <= '0;
         pipe_q     <= {STG{PIX_IDLE}};
         hsync_q    <= ~SYNC_POL;
         vsync_q    <= ~SYNC_POL;
         video_q    <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         rgb_q      <= '0;
      end else begin
         mode_q     <= mode_d;
         scale_q    <= scale_d;
         row_base_q <= row_base_d;
         bar_idx_q  <= bar_idx_d;
         bar_pos_q  <= bar_pos_d;
         addr_q     <= addr_d;
         pipe_q[0]  <= pix0;
         for (int i = 1; i < STG; i++) pipe_q[i] <= pipe_q[i-1];
         hsync_q    <= last.hsync;
         vsync_q    <= last.vsync;
         video_q    <= last.video;
         x_q        <= last.x;
         y_q        <= last.y;
         rgb_q      <= rgb_d;
      end
   end

   assign fb.pix_addr = addr_q;
   assign fb.pix_rd   = pipe_q[0].rd;

   assign o_hsync = hsync_q;
   assign o_vsync = vsync_q;
   assign o_video = video_q;
   assign o_x     = x_q;
   assign o_y     = y_q;
   assign o_red   = rgb_q[3*CH_W-1:2*CH_W];
   assign o_green = rgb_q[2*CH_W-1:CH_W];
   assign o_blue  = rgb_q[CH_W-1:0];

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Scoreboard bench: a raster reference model pushes expected pins / read-port values per clock,
// a negedge monitor pops and compares them as they come due.
module tb_vga_display_ctrl;
   localparam int HA = 64, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
   localparam int VA = 24, VFP = 2, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;
   localparam int CH_W = 4, PIX_W = 12, FB_W = 48, FB_H = 20, ADDR_W = 11, LAT = 2;
   localparam int XW = $clog2(HT), YW = $clog2(VT);
   localparam int NFR = 10;
   localparam int RST_POS = 10 * HT + 30;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [1:0] mode = 2'd0;
   logic scale = 1'b0;
   logic hs, vs, vid, fs;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [CH_W-1:0] r, g, b;

   vga_display_ctrl_if #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) fb_if ();

   vga_display_ctrl #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_POL(1'b0), .CH_W(CH_W), .FB_W(FB_W), .FB_H(FB_H),
      .ADDR_W(ADDR_W), .BRAM_LAT(LAT)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_scale(scale), .fb(fb_if),
      .o_hsync(hs), .o_vsync(vs), .o_video(vid), .o_x(x), .o_y(y),
      .o_red(r), .o_green(g), .o_blue(b), .o_frame_start(fs)
   );

   always #5 clk = ~clk;

   function automatic logic [PIX_W-1:0] fb_val(input int a);
      return PIX_W'(a * 37 + 11);
   endfunction

   // BRAM model: garbage when not read, so a design using unrequested data gets caught
   logic [PIX_W-1:0] bq [LAT];
   always @(posedge clk) begin
      bq[0] <= fb_if.pix_rd ? fb_val(int'(fb_if.pix_addr)) : PIX_W'($urandom);
      for (int i = 1; i < LAT; i++) bq[i] <= bq[i-1];
   end
   assign fb_if.pix_data = bq[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0, n_fail = 0;

   typedef struct {int due; logic hs, vs, vid; int x, y; logic [11:0] rgb;} pin_t;
   typedef struct {int due; logic rd; int addr; logic fs;} rd_t;
   pin_t pin_q[$];
   rd_t  rd_q[$];
   int fmode = 0, fscale = 0;

   function automatic logic [11:0] exp_rgb(input int h, input int v, input int m, input int s);
      int fx, fy, bar;
      if (h >= HA || v >= VA) return 12'h000;
      case (m)
         0: begin
            fx = h >> s; fy = v >> s;
            if (fx < FB_W && fy < FB_H) return fb_val(fy * FB_W + fx);
            return 12'h000;
         end
         1: begin
            bar = h / (HA / 8);
            return {{4{bar == 0 || bar == 1 || bar == 4 || bar == 5}},
                    {4{bar < 4}},
                    {4{(bar % 2) == 0 && bar < 7}}};
         end
         2: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
         default: return 12'h00F;
      endcase
   endfunction

   // n = raster position the DUT counter samples at the coming posedge
   task automatic issue(input int n);
      int h, v, fx, fy;
      pin_t p;
      rd_t q;
      if (n % FRAME == 0) begin fmode = int'(mode); fscale = int'(scale); end
      h = n % HT; v = (n / HT) % VT;
      p.due = cyc + LAT + 2;
      p.hs  = !(h >= HA + HFP && h < HA + HFP + HS);
      p.vs  = !(v >= VA + VFP && v < VA + VFP + VS);
      p.vid = (h < HA) && (v < VA);
      p.x = h; p.y = v;
      p.rgb = exp_rgb(h, v, fmode, fscale);
      fx = h >> fscale; fy = v >> fscale;
      q.due  = cyc + 1;
      q.rd   = p.vid && fmode == 0 && fx < FB_W && fy < FB_H;
      q.addr = fy * FB_W + fx;
      q.fs   = (n % FRAME == 0);
      pin_q.push_back(p);
      rd_q.push_back(q);
   endtask

   task automatic chk_reset(input string tag);
      n_tests++;
      if (hs !== 1'b1 || vs !== 1'b1 || vid !== 1'b0 || x !== '0 || y !== '0 ||
          {r, g, b} !== 12'h000 || fs !== 1'b0 || fb_if.pix_rd !== 1'b0 || fb_if.pix_addr !== '0) begin
         n_fail++;
         $display("FAIL %s: got hs=%b vs=%b vid=%b x=%0d y=%0d rgb=%h fs=%b rd=%b addr=%0d, expected 1 1 0 0 0 000 0 0 0",
                  tag, hs, vs, vid, x, y, {r, g, b}, fs, fb_if.pix_rd, fb_if.pix_addr);
      end
   endtask

   pin_t e;
   rd_t  q;
   always @(negedge clk) begin
      if (!rst) begin
         if (pin_q.size() > 0 && pin_q[0].due == cyc) begin
            e = pin_q.pop_front();
            n_tests++;
            if (hs !== e.hs || vs !== e.vs || vid !== e.vid || x !== XW'(e.x) ||
                y !== YW'(e.y) || {r, g, b} !== e.rgb) begin
               n_fail++;
               $display("FAIL pins cyc=%0d mode=%0d: got hs=%b vs=%b vid=%b x=%0d y=%0d rgb=%h, expected hs=%b vs=%b vid=%b x=%0d y=%0d rgb=%h",
                        cyc, fmode, hs, vs, vid, x, y, {r, g, b}, e.hs, e.vs, e.vid, e.x, e.y, e.rgb);
            end
         end
         if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            q = rd_q.pop_front();
            n_tests++;
            if (fb_if.pix_rd !== q.rd || fs !== q.fs ||
                (q.rd && fb_if.pix_addr !== ADDR_W'(q.addr))) begin
               n_fail++;
               $display("FAIL readport cyc=%0d: got rd=%b addr=%0d fs=%b, expected rd=%b addr=%0d fs=%b",
                        cyc, fb_if.pix_rd, fb_if.pix_addr, fs, q.rd, q.addr, q.fs);
            end
         end
      end
   end

   initial begin
      int n, k, t_chg;
      bit did_rst;
      int plan_m [NFR+1];
      int plan_s [NFR+1];
      plan_m = '{0, 0, 1, 2, 3, 0, 1, 2, 0, 3, 0};
      plan_s = '{0, 1, 0, 1, 0, 1, 1, 0, 0, 1, 1};
      for (int i = 8; i <= NFR; i++) begin
         plan_m[i] = $urandom_range(0, 3);
         plan_s[i] = $urandom_range(0, 1);
      end
      mode = 2'(plan_m[0]);
      scale = plan_s[0][0];
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      n = 0; k = 0; did_rst = 1'b0;
      t_chg = $urandom_range(1, FRAME - 1);
      while (k < NFR) begin
         if (!did_rst && k == 4 && (n % FRAME) == RST_POS) begin
            did_rst = 1'b1;
            rst = 1'b1;
            pin_q.delete();
            rd_q.delete();
            #1 chk_reset("rst_assert");
            repeat (3) begin
               @(negedge clk);
               chk_reset("rst_hold");
            end
            rst = 1'b0;
            n = 0;
         end
         if ((n % FRAME) == t_chg) begin
            mode  = 2'(plan_m[k+1]);
            scale = plan_s[k+1][0];
         end
         issue(n);
         n++;
         if (n % FRAME == 0) begin
            k++;
            t_chg = $urandom_range(1, FRAME - 1);
         end
         @(negedge clk);
      end
      repeat (LAT + 4) @(negedge clk);
      n_tests++;
      if (pin_q.size() != 0 || rd_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", pin_q.size(), rd_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
